// File: rtl/temp_sensor_pkg.sv
// temp_sensor_pkg: shared FSM state, default timing parameters and averaging depth
package temp_sensor_pkg;
  typedef enum logic [1:0] {IDLE, SETUP, SHIFT, DONE} state_t;
  localparam int DEF_CLK_DIV = 10;
  localparam int DEF_DATA_BITS = 16;
  localparam int AVG_DEPTH = 4;
endpackage

// File: rtl/temp_sensor_reader_shift.sv
// temp_spi_shift: SCLK divider, bit counter and MSB-first MISO shift register
module temp_spi_shift
  import temp_sensor_pkg::*;
#(
  parameter int CLK_DIV = DEF_CLK_DIV,
  parameter int DATA_BITS = DEF_DATA_BITS
) (
  input  logic                 clk_fix,
  input  logic                 rst_fix,
  input  logic                 start,
  input  logic                 abort,
  input  logic                 miso,
  output logic                 busy,
  output logic                 sclk,
  output logic                 frame_valid,
  output logic [DATA_BITS-1:0] frame
);
  localparam int CW = $clog2(CLK_DIV);
  localparam int BW = $clog2(DATA_BITS);
  localparam logic [CW-1:0] DIV_MAX = CW'(CLK_DIV - 1);
  localparam logic [BW-1:0] BIT_MAX = BW'(DATA_BITS - 1);
  logic                 setup;
  logic                 tick;
  logic [CW-1:0]        div;
  logic [BW-1:0]        bit_cnt;
  logic [DATA_BITS-1:0] sh;
  always_comb begin
    tick = busy && div == DIV_MAX;
    frame = {sh[DATA_BITS-2:0], miso};
    frame_valid = tick && !setup && sclk && bit_cnt == BIT_MAX;
  end
  // setup phase keeps SCLK high for one divider period before the first bit
  always_ff @(posedge clk_fix) begin
    if (rst_fix || abort) begin
      busy <= 1'b0;
      setup <= 1'b0;
      sclk <= 1'b1;
      div <= '0;
      bit_cnt <= '0;
      sh <= '0;
    end else if (start) begin
      busy <= 1'b1;
      setup <= 1'b1;
      div <= '0;
      bit_cnt <= '0;
    end else if (busy) begin
      div <= tick ? '0 : div + 1'b1;
      if (tick && setup) begin
        setup <= 1'b0;
        sclk <= 1'b0;
      end else if (tick && !sclk) begin
        sclk <= 1'b1;
      end else if (tick) begin
        sh <= frame;
        sclk <= frame_valid;
        busy <= !frame_valid;
        bit_cnt <= frame_valid ? '0 : bit_cnt + 1'b1;
      end
    end
  end
endmodule

// File: rtl/temp_sensor_reader.sv
// temp_sensor_reader: SPI mode-3 temperature read engine; TEMP_AVG_EN enables 4-reading signed averaging
module temp_sensor_reader
  import temp_sensor_pkg::*;
#(
  parameter int CLK_DIV = DEF_CLK_DIV,
  parameter int DATA_BITS = DEF_DATA_BITS
) (
  input  logic                 clk_fix,
  input  logic                 rst_fix,
  input  logic                 cs_n_req,
  input  logic                 spi_miso,
  output logic                 spi_sclk,
  output logic                 spi_cs_n,
  output logic [DATA_BITS-1:0] temp_data,
  output logic                 temp_valid,
  output logic                 temp_done
);
  state_t               state, state_nx;
  logic                 req_q;
  logic [1:0]           miso_sync;
  logic                 start, abort, pub, busy, frame_valid;
  logic [DATA_BITS-1:0] frame;
  logic                 done_set, data_set;
  logic [DATA_BITS-1:0] data_nx;
  temp_spi_shift #(.CLK_DIV(CLK_DIV), .DATA_BITS(DATA_BITS)) u_shift (
    .clk_fix    (clk_fix),
    .rst_fix    (rst_fix),
    .start      (start),
    .abort      (abort),
    .miso       (miso_sync[1]),
    .busy       (busy),
    .sclk       (spi_sclk),
    .frame_valid(frame_valid),
    .frame      (frame)
  );
  always_comb begin
    state_nx = state;
    start = 1'b0;
    abort = 1'b0;
    pub = 1'b0;
    case (state)
      IDLE: if (!req_q && !temp_done) begin
        state_nx = SETUP;
        start = 1'b1;
      end
      SETUP, SHIFT: if (req_q) begin
        state_nx = IDLE;
        abort = 1'b1;
      end else if (frame_valid) begin
        state_nx = DONE;
        pub = 1'b1;
      end else if (state == SETUP && busy && !spi_sclk) begin
        state_nx = SHIFT;
      end
      DONE: if (req_q) state_nx = IDLE;
      default: state_nx = IDLE;
    endcase
  end
`ifdef TEMP_AVG_EN
  logic [DATA_BITS-1:0]        hist [AVG_DEPTH];
  logic                        pub_q;
  logic signed [DATA_BITS+1:0] sum;
  always_comb begin
    sum = '0;
    for (int i = 0; i < AVG_DEPTH; i++) sum = sum + {{2{hist[i][DATA_BITS-1]}}, hist[i]};
    done_set = pub_q;
    data_set = pub_q;
    data_nx = sum[DATA_BITS+1:2];
  end
  // the first reading after reset seeds the whole history so the mean starts settled
  always_ff @(posedge clk_fix) begin
    if (rst_fix) begin
      pub_q <= 1'b0;
      for (int i = 0; i < AVG_DEPTH; i++) hist[i] <= '0;
    end else begin
      pub_q <= pub;
      if (pub) begin
        hist[0] <= frame;
        for (int i = 1; i < AVG_DEPTH; i++) hist[i] <= temp_valid ? hist[i-1] : frame;
      end
    end
  end
`else
  always_comb begin
    done_set = pub;
    data_set = pub;
    data_nx = frame;
  end
`endif
  always_ff @(posedge clk_fix) begin
    if (rst_fix) begin
      state <= IDLE;
      req_q <= 1'b1;
      miso_sync <= '0;
      spi_cs_n <= 1'b1;
      temp_data <= '0;
      temp_valid <= 1'b0;
      temp_done <= 1'b0;
    end else begin
      state <= state_nx;
      req_q <= cs_n_req;
      miso_sync <= {miso_sync[0], spi_miso};
      spi_cs_n <= !(state_nx == SETUP || state_nx == SHIFT);
      if (pub) temp_valid <= 1'b1;
      if (state == DONE && req_q) temp_done <= 1'b0;
      else if (done_set) temp_done <= 1'b1;
      if (data_set) temp_data <= data_nx;
    end
  end
endmodule

// File: tb/tb_temp_sensor_reader.sv
// tb_temp_sensor_reader: randomized reads against a behavioural sensor and reading-history model
module tb_temp_sensor_reader;
  localparam int CD = 10;
  localparam int CD2 = 2;
  localparam int DB = 16;
`ifdef TEMP_AVG_EN
  localparam int DLY = 1;
`else
  localparam int DLY = 0;
`endif
  logic clk_fix = 1'b0;
  logic rst_fix = 1'b1;
  logic cs_n_req = 1'b1, spi_miso = 1'b0, spi_sclk, spi_cs_n, temp_valid, temp_done;
  logic cs_n_req2 = 1'b1, spi_miso2 = 1'b0, spi_sclk2, spi_cs_n2, temp_valid2, temp_done2;
  logic [DB-1:0] temp_data, temp_data2;
  logic [DB-1:0] sens_word = '0, sens_word2 = '0, exp_data = '0;
  logic [DB-1:0] hist[$];
  int sens_idx = 0, sens_idx2 = 0, errors = 0, checks = 0;

  always #5 clk_fix = ~clk_fix;

  temp_sensor_reader #(.CLK_DIV(CD), .DATA_BITS(DB)) dut (
    .clk_fix(clk_fix), .rst_fix(rst_fix), .cs_n_req(cs_n_req), .spi_miso(spi_miso),
    .spi_sclk(spi_sclk), .spi_cs_n(spi_cs_n), .temp_data(temp_data),
    .temp_valid(temp_valid), .temp_done(temp_done)
  );
  temp_sensor_reader #(.CLK_DIV(CD2), .DATA_BITS(DB)) dut2 (
    .clk_fix(clk_fix), .rst_fix(rst_fix), .cs_n_req(cs_n_req2), .spi_miso(spi_miso2),
    .spi_sclk(spi_sclk2), .spi_cs_n(spi_cs_n2), .temp_data(temp_data2),
    .temp_valid(temp_valid2), .temp_done(temp_done2)
  );

  // mode-3 sensors: next bit, MSB first, is driven on each SCLK falling edge
  always @(negedge spi_sclk or posedge spi_cs_n)
    if (spi_cs_n) sens_idx = 0;
    else if (sens_idx < DB) begin
      spi_miso = sens_word[DB-1-sens_idx];
      sens_idx++;
    end
  always @(negedge spi_sclk2 or posedge spi_cs_n2)
    if (spi_cs_n2) sens_idx2 = 0;
    else if (sens_idx2 < DB) begin
      spi_miso2 = sens_word2[DB-1-sens_idx2];
      sens_idx2++;
    end

  initial begin
    #5_000_000;
    $display("FAIL watchdog: simulation did not finish, errors=%0d", errors);
    $fatal(1);
  end

  task automatic model_publish(input logic [DB-1:0] w);
    int s = 0;
`ifdef TEMP_AVG_EN
    if (hist.size() == 0) repeat (3) hist.push_front(w);
`endif
    hist.push_front(w);
    while (hist.size() > 4) void'(hist.pop_back());
`ifdef TEMP_AVG_EN
    foreach (hist[i]) s += int'($signed(hist[i]));
    exp_data = DB'(s >>> 2);
`else
    s = 0;
    exp_data = hist[0];
`endif
  endtask

  task automatic do_reset();
    @(posedge clk_fix);
    #1 rst_fix = 1'b1; cs_n_req = 1'b1; cs_n_req2 = 1'b1;
    repeat (2) @(posedge clk_fix);
    #1 rst_fix = 1'b0;
    hist.delete();
    exp_data = '0;
  endtask

  task automatic read_check(input string name, input logic [DB-1:0] w);
    int done_edge = -1, cs_first = -1, cs_last = -1, falls = 0, minw = 999, maxw = 0, run = 0;
    sens_word = w;
    model_publish(w);
    @(posedge clk_fix);
    #1 cs_n_req = 1'b0;
    @(posedge clk_fix);
    for (int k = 1; k <= 1000 && done_edge < 0; k++) begin
      @(posedge clk_fix);
      #1;
      if (!spi_cs_n) begin
        if (cs_first < 0) cs_first = k;
        cs_last = k;
      end
      if (!spi_sclk) run++;
      else if (run > 0) begin
        falls++;
        minw = run < minw ? run : minw;
        maxw = run > maxw ? run : maxw;
        run = 0;
      end
      if (temp_done === 1'b1) done_edge = k;
    end
    checks++; if (done_edge !== 1 + CD * (1 + 2 * DB) + DLY) begin errors++; $display("FAIL %s done_edge: got %0d expected %0d", name, done_edge, 1 + CD * (1 + 2 * DB) + DLY); end
    checks++; if (cs_first !== 1 || cs_last !== CD * (1 + 2 * DB)) begin errors++; $display("FAIL %s cs_window: got %0d..%0d expected 1..%0d", name, cs_first, cs_last, CD * (1 + 2 * DB)); end
    checks++; if (falls !== DB || minw !== CD || maxw !== CD) begin errors++; $display("FAIL %s sclk_pulses: got %0d pulses width %0d..%0d expected %0d of %0d", name, falls, minw, maxw, DB, CD); end
    checks++; if (temp_data !== exp_data) begin errors++; $display("FAIL %s temp_data: got %h expected %h", name, temp_data, exp_data); end
    checks++; if (temp_valid !== 1'b1) begin errors++; $display("FAIL %s temp_valid: got %b expected 1", name, temp_valid); end
  endtask

  task automatic release_check(input string name);
    int k = 0;
    @(posedge clk_fix);
    #1 cs_n_req = 1'b1;
    while (temp_done === 1'b1 && k < 20) begin
      @(posedge clk_fix);
      #1 k++;
    end
    checks++; if (k !== 2) begin errors++; $display("FAIL %s done_release: got %0d edges expected 2", name, k); end
  endtask

  task automatic test_reset();
    repeat (3) @(posedge clk_fix);
    #1;
    checks++; if ({spi_cs_n, spi_sclk, temp_valid, temp_done, temp_data} !== {4'b1100, 16'h0}) begin errors++; $display("FAIL reset_state: got cs_n=%b sclk=%b valid=%b done=%b data=%h expected 1 1 0 0 0000", spi_cs_n, spi_sclk, temp_valid, temp_done, temp_data); end
    checks++; if ({spi_cs_n2, spi_sclk2, temp_valid2, temp_done2, temp_data2} !== {4'b1100, 16'h0}) begin errors++; $display("FAIL reset_state2: got cs_n=%b sclk=%b valid=%b done=%b data=%h expected 1 1 0 0 0000", spi_cs_n2, spi_sclk2, temp_valid2, temp_done2, temp_data2); end
    rst_fix = 1'b0;
  endtask

  task automatic test_basic();
    read_check("basic", 16'h0C80);
    release_check("basic");
  endtask

  task automatic test_hold();
    int cs_lo = 0, done_lo = 0;
    read_check("hold", DB'($urandom));
    repeat (1000) begin
      @(posedge clk_fix);
      #1;
      if (spi_cs_n !== 1'b1) cs_lo++;
      if (temp_done !== 1'b1) done_lo++;
    end
    checks++; if (cs_lo !== 0) begin errors++; $display("FAIL hold_retrigger: got %0d cycles cs_n low expected 0", cs_lo); end
    checks++; if (done_lo !== 0) begin errors++; $display("FAIL hold_done: got %0d cycles done low expected 0", done_lo); end
    release_check("hold");
  endtask

  task automatic test_abort();
    logic [DB-1:0] prev = exp_data;
    int done_seen = 0;
    sens_word = DB'($urandom);
    @(posedge clk_fix);
    #1 cs_n_req = 1'b0;
    @(posedge clk_fix);
    repeat (1 + CD + 2 * CD * 5 + 3) @(posedge clk_fix);
    #1;
    checks++; if (spi_cs_n !== 1'b0) begin errors++; $display("FAIL abort_in_transfer: got cs_n=%b expected 0", spi_cs_n); end
    cs_n_req = 1'b1;
    repeat (2) @(posedge clk_fix);
    #1;
    checks++; if ({spi_cs_n, spi_sclk} !== 2'b11) begin errors++; $display("FAIL abort_idle: got cs_n=%b sclk=%b expected 1 1", spi_cs_n, spi_sclk); end
    repeat (400) begin
      @(posedge clk_fix);
      #1 if (temp_done !== 1'b0) done_seen++;
    end
    checks++; if (done_seen !== 0) begin errors++; $display("FAIL abort_done: got %0d cycles done high expected 0", done_seen); end
    checks++; if (temp_data !== prev || temp_valid !== 1'b1) begin errors++; $display("FAIL abort_data: got %h valid %b expected %h valid 1", temp_data, temp_valid, prev); end
  endtask

  task automatic test_random();
    for (int i = 0; i < 3; i++) begin
      read_check("random", DB'($urandom));
      release_check("random");
    end
  endtask

  task automatic test_reset_mid();
    sens_word = DB'($urandom);
    @(posedge clk_fix);
    #1 cs_n_req = 1'b0;
    repeat (150) @(posedge clk_fix);
    #1 rst_fix = 1'b1; cs_n_req = 1'b1;
    @(posedge clk_fix);
    #1;
    checks++; if ({spi_cs_n, spi_sclk, temp_valid, temp_done, temp_data} !== {4'b1100, 16'h0}) begin errors++; $display("FAIL reset_mid: got cs_n=%b sclk=%b valid=%b done=%b data=%h expected 1 1 0 0 0000", spi_cs_n, spi_sclk, temp_valid, temp_done, temp_data); end
    rst_fix = 1'b0;
    hist.delete();
    exp_data = '0;
    read_check("after_reset", DB'($urandom));
    release_check("after_reset");
  endtask

  task automatic test_div2();
    int done_edge = -1;
    sens_word2 = 16'hAAAA;
    @(posedge clk_fix);
    #1 cs_n_req2 = 1'b0;
    @(posedge clk_fix);
    for (int k = 1; k <= 300 && done_edge < 0; k++) begin
      @(posedge clk_fix);
      #1 if (temp_done2 === 1'b1) done_edge = k;
    end
    checks++; if (done_edge !== 1 + CD2 * (1 + 2 * DB) + DLY) begin errors++; $display("FAIL div2_done_edge: got %0d expected %0d", done_edge, 1 + CD2 * (1 + 2 * DB) + DLY); end
    checks++; if (temp_data2 !== 16'hAAAA || temp_valid2 !== 1'b1) begin errors++; $display("FAIL div2_data: got %h valid %b expected aaaa valid 1", temp_data2, temp_valid2); end
  endtask

  task automatic test_avg();
    logic [DB-1:0] seq [4] = '{16'h0100, 16'h0100, 16'h0200, 16'h0400};
    do_reset();
    foreach (seq[i]) begin
      read_check("avg_seq", seq[i]);
      release_check("avg_seq");
    end
    do_reset();
    read_check("avg_zero", 16'h0000);
    release_check("avg_zero");
    read_check("avg_negative", 16'hFF00);
    release_check("avg_negative");
  endtask

  initial begin
    test_reset();
    test_basic();
    test_hold();
    test_abort();
    test_random();
    test_reset_mid();
    test_div2();
    test_avg();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
